booth_mult: RTL and testbench



---
 rtl/booth_mult_pkg.sv | 27 ++
 rtl/booth_mult_if.sv | 23 ++
 rtl/booth_mult_recoder.sv | 22 ++
 rtl/booth_mult.sv | 116 +++++++++++
 tb/tb_booth_mult.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/booth_mult_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
package booth_mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   // Partial-product select: magnitude is zero, x1 or x2; neg negates it.
   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_digit_t;

   localparam booth_digit_t DIGIT_ZERO = '{neg: 1'b0, one: 1'b0, two: 1'b0};
   localparam booth_digit_t DIGIT_POS1 = '{neg: 1'b0, one: 1'b1, two: 1'b0};
   localparam booth_digit_t DIGIT_POS2 = '{neg: 1'b0, one: 1'b0, two: 1'b1};
   localparam booth_digit_t DIGIT_NEG1 = '{neg: 1'b1, one: 1'b1, two: 1'b0};
   localparam booth_digit_t DIGIT_NEG2 = '{neg: 1'b1, one: 1'b0, two: 1'b1};

   function automatic int unsigned ITER(input int unsigned width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_mult_if.sv
// Operand/product handshake bundle for booth_mult.
interface booth_mult_if #(
   parameter int unsigned WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 is_signed;
   logic [WIDTH-1:0]     multiplier;
   logic [WIDTH-1:0]     multiplicand;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output in_valid, is_signed, multiplier, multiplicand, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, is_signed, multiplier, multiplicand, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/booth_mult_recoder.sv
// Radix-4 Booth recoder: 3-bit multiplier window to a signed digit select.
module booth_recoder
   import booth_mult_pkg::*;
(
   input  logic [2:0]   window,
   output booth_digit_t digit
);

   always_comb begin
      digit = DIGIT_ZERO;
      case (window)
         3'b001,
         3'b010:  digit = DIGIT_POS1;
         3'b011:  digit = DIGIT_POS2;
         3'b100:  digit = DIGIT_NEG2;
         3'b101,
         3'b110:  digit = DIGIT_NEG1;
         default: digit = DIGIT_ZERO;
      endcase
   end

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-4 Booth multiplier, signed/unsigned, valid/ready on both sides.
module booth_mult
   import booth_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input logic          clk,
   input logic          rst,
   booth_mult_if.slave  bus
);

   localparam int unsigned NITER = ITER(WIDTH);
   localparam int unsigned CW    = $clog2(NITER);
   localparam int unsigned EW    = WIDTH + 2;
   localparam int unsigned HW    = WIDTH + 3;
   localparam int unsigned PW    = HW + EW + 1;

   if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("booth_mult: WIDTH must be even and >= 4");
   end

   state_t              state;
   state_t              state_next;
   logic [CW-1:0]       iter;
   logic [PW-1:0]       acc;
   logic [PW-1:0]       acc_sum;
   logic [PW-1:0]       acc_next;
   logic [EW-1:0]       mcand;
   logic [EW-1:0]       a_ext;
   logic [EW-1:0]       b_ext;
   logic [HW-1:0]       mcand_x;
   logic [HW-1:0]       mag;
   logic [HW-1:0]       addend;
   logic [HW-1:0]       hi_sum;
   logic [2*WIDTH-1:0]  product_q;
   logic                accept;
   logic                last;
   booth_digit_t        digit;

   assign accept = bus.in_valid && (state == IDLE);
   assign last   = (iter == CW'(NITER - 1));

   // The mode is folded into the extension here, so it need not be kept past accept.
   assign a_ext = {{2{bus.is_signed & bus.multiplier[WIDTH-1]}},   bus.multiplier};
   assign b_ext = {{2{bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};

   booth_recoder u_recoder (
      .window (acc[2:0]),
      .digit  (digit)
   );

   // acc = {upper half (HW), multiplier field (EW), bit -1}; product ends up in acc[2*WIDTH:1].
   always_comb begin
      mcand_x = {mcand[EW-1], mcand};
      mag     = '0;
      if (digit.two) begin
         mag = mcand_x << 1;
      end else if (digit.one) begin
         mag = mcand_x;
      end
      addend   = digit.neg ? (~mag + HW'(1)) : mag;
      hi_sum   = acc[PW-1 -: HW] + addend;
      acc_sum  = {hi_sum, acc[EW:0]};
      acc_next = $signed(acc_sum) >>> 2;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_next = CALC;
         CALC:    if (last)          state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default:                    state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iter      <= '0;
         acc       <= '0;
         mcand     <= '0;
         product_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc   <= {{HW{1'b0}}, a_ext, 1'b0};
                  mcand <= b_ext;
                  iter  <= '0;
               end
            end
            CALC: begin
               acc  <= acc_next;
               iter <= iter + 1'b1;
               if (last) begin
                  product_q <= acc_next[2*WIDTH:1];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.product   = product_q;

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult (WIDTH=16): vector table, corner sequences, random traffic.
module tb_booth_mult;

   localparam int unsigned W   = 16;
   localparam int          LAT = 9;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   booth_mult_if #(.WIDTH(W)) bus ();

   booth_mult #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
      longint x;
      longint y;
      x = s ? longint'($signed(a)) : longint'({48'b0, a});
      y = s ? longint'($signed(b)) : longint'({48'b0, b});
      return 32'(x * y);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full transaction; the inputs are scrambled after accept to prove they were captured.
   task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input bit rand_ready, output logic [31:0] prod, output int lat);
      int  bound;
      logic r;
      bus.multiplier   = a;
      bus.multiplicand = b;
      bus.is_signed    = s;
      bus.in_valid     = 1'b1;
      bound = 0;
      while (!bus.in_ready && bound < 50) begin
         step();
         bound++;
      end
      check("in_ready_wait", 64'(bus.in_ready), 64'(1));
      step();
      bus.in_valid     = 1'b0;
      bus.multiplier   = 16'($urandom);
      bus.multiplicand = 16'($urandom);
      bus.is_signed    = ~s;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         step();
         lat++;
      end
      check("out_valid_wait", 64'(bus.out_valid), 64'(1));
      prod = bus.product;
      for (int k = 0; k < 100; k++) begin
         r = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.out_ready = r;
         step();
         if (r) break;
         check("hold_prod", 64'(bus.product), 64'(prod));
      end
      bus.out_ready = 1'b0;
      check("post_hs_in_ready", 64'(bus.in_ready), 64'(1));
   endtask

   initial begin
      logic [31:0] p;
      logic [31:0] p0;
      logic [31:0] e0;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      int          lat;

      checks   = 0;
      failures = 0;

      vecs[0] = '{a: 16'hFFFF, b: 16'hFFFF, s: 1'b0, exp: 32'hFFFE0001};
      vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, s: 1'b1, exp: 32'h00000001};
      vecs[2] = '{a: 16'h8000, b: 16'h8000, s: 1'b1, exp: 32'h40000000};
      vecs[3] = '{a: 16'h0003, b: 16'hFFFB, s: 1'b1, exp: 32'hFFFFFFF1};
      vecs[4] = '{a: 16'h8000, b: 16'h0002, s: 1'b0, exp: 32'h00010000};
      vecs[5] = '{a: 16'h8000, b: 16'h0002, s: 1'b1, exp: 32'hFFFF0000};
      vecs[6] = '{a: 16'h7FFF, b: 16'h8000, s: 1'b1, exp: 32'hC0008000};
      vecs[7] = '{a: 16'h0000, b: 16'h1234, s: 1'b1, exp: 32'h00000000};
      vecs[8] = '{a: 16'hFFFF, b: 16'h0001, s: 1'b0, exp: 32'h0000FFFF};
      vecs[9] = '{a: 16'h8000, b: 16'h8000, s: 1'b0, exp: 32'h40000000};

      rst              = 1'b0;
      bus.in_valid     = 1'b0;
      bus.out_ready    = 1'b0;
      bus.is_signed    = 1'b0;
      bus.multiplier   = '0;
      bus.multiplicand = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'(1));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_product", 64'(bus.product), 64'(0));
      rst = 1'b1;
      step();

      for (int i = 0; i < 10; i++) begin
         run_txn(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, p, lat);
         check($sformatf("vec%0d_prod", i), 64'(p), 64'(vecs[i].exp));
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
      end

      // Back-pressure: product held, in_ready low, new operands ignored.
      e0 = ref_prod(16'h1234, 16'h5678, 1'b0);
      bus.multiplier   = 16'h1234;
      bus.multiplicand = 16'h5678;
      bus.is_signed    = 1'b0;
      bus.in_valid     = 1'b1;
      step();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         step();
         lat++;
      end
      check("bp_lat", 64'(lat), 64'(LAT));
      p0 = bus.product;
      check("bp_prod0", 64'(p0), 64'(e0));
      bus.multiplier   = 16'h0101;
      bus.multiplicand = 16'h0202;
      bus.is_signed    = 1'b1;
      bus.in_valid     = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         check("bp_out_valid", 64'(bus.out_valid), 64'(1));
         check("bp_prod", 64'(bus.product), 64'(e0));
         check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("bp_rel_out_valid", 64'(bus.out_valid), 64'(0));
      check("bp_rel_in_ready", 64'(bus.in_ready), 64'(1));
      step();
      check("bp_idle_stays", 64'(bus.in_ready), 64'(1));

      // Asynchronous reset after four digits have been retired.
      bus.multiplier   = 16'hFFFF;
      bus.multiplicand = 16'hFFFF;
      bus.is_signed    = 1'b0;
      bus.in_valid     = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("mid_busy", 64'(bus.in_ready), 64'(0));
      repeat (4) step();
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("mid_rst_product", 64'(bus.product), 64'(0));
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
      step();
      rst = 1'b1;
      step();
      run_txn(16'd7, 16'd6, 1'b0, 1'b0, p, lat);
      check("post_rst_prod", 64'(p), 64'(42));
      check("post_rst_lat", 64'(lat), 64'(LAT));

      // Random traffic with corner-biased operands and random stalls.
      for (int n = 0; n < 3000; n++) begin
         case ($urandom_range(0, 7))
            0:       ra = 16'h8000;
            1:       ra = 16'hFFFF;
            2:       ra = 16'h7FFF;
            3:       ra = 16'h0000;
            default: ra = 16'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0:       rb = 16'h8000;
            1:       rb = 16'hFFFF;
            2:       rb = 16'h0001;
            default: rb = 16'($urandom);
         endcase
         rs = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 2)) step();
         run_txn(ra, rb, rs, 1'b1, p, lat);
         check("rand_prod", 64'(p), 64'(ref_prod(ra, rb, rs)));
         check("rand_lat", 64'(lat), 64'(LAT));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
